apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Parametrised APB4 master: converts a valid/ready command port into APB SETUP/ACCESS transfers
//  to one of NSLV slaves (one-hot psel decoded from address), with wait states (pready),
//  slave error (pslverr), byte strobes, wait-state timeout and a held response handshake.
//  Sits between the system-side requester and the APB slave array in the apbmain subsystem.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width; multiple of 8
//  NSLV     4   number of slaves, 1..16; psel width
//  SLV_LSB  12  LSB of slave-select field paddr[SLV_LSB +: SW], SW = max(1, clog2(NSLV))
//  TIMEOUT  16  max ACCESS cycles waiting for pready before abort, >= 2
// PORTS
//  pclk        in   1         APB clock, all logic on rising edge
//  prst_n      in   1         asynchronous active-low reset
//  cmd_valid   in   1         command request
//  cmd_ready   out  1         command accepted when cmd_valid && cmd_ready
//  cmd_write   in   1         1 = write, 0 = read
//  cmd_addr    in   ADDR_W    transfer address
//  cmd_wdata   in   DATA_W    write data
//  cmd_strb    in   DATA_W/8  write byte strobes
//  rsp_valid   out  1         response available, held until rsp_ready
//  rsp_ready   in   1         response consumed when rsp_valid && rsp_ready
//  rsp_rdata   out  DATA_W    read data (0 for writes and errors)
//  rsp_err     out  1         pslverr, decode error or timeout
//  rsp_tout    out  1         error caused by timeout
//  psel        out  NSLV      one-hot slave select
//  penable     out  1         APB access phase
//  pwrite      out  1         APB direction
//  paddr       out  ADDR_W    APB address
//  pwdata      out  DATA_W    APB write data
//  pstrb       out  DATA_W/8  APB strobes (0 on reads)
//  pready      in   1         slave ready
//  prdata      in   DATA_W    slave read data
//  pslverr     in   1         slave error, sampled with pready
// BEHAVIOUR
//  Reset (prst_n=0, async): state IDLE; cmd_ready=1; psel=0, penable=0, pwrite=0, paddr=0,
//   pwdata=0, pstrb=0; rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_tout=0; timer=0.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; at most one command in flight.
//  IDLE: cmd_ready=1. On accept, register write/addr/wdata/strb (pstrb forced 0 if read);
//   idx = cmd_addr[SLV_LSB +: SW]. idx < NSLV -> SETUP; idx >= NSLV -> RESP with rsp_err=1,
//   rsp_tout=0, rsp_rdata=0, no APB activity (decode error).
//  SETUP (1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb valid; -> ACCESS.
//  ACCESS: psel held, penable=1, all APB outputs stable; timer increments each cycle pready=0.
//   pready=1: capture rsp_rdata = read ? prdata : 0, rsp_err = pslverr, rsp_tout=0; -> RESP.
//   pready=0 with timer == TIMEOUT-1: abort; rsp_err=1, rsp_tout=1, rsp_rdata=0; -> RESP.
//   Zero-wait transfer = 2 APB cycles; cmd accept to rsp_valid = 3 cycles minimum.
//  RESP: psel=0, penable=0, timer=0; rsp_valid=1 with stable data until rsp_valid && rsp_ready,
//   then -> IDLE. rsp_ready ignored when rsp_valid=0. cmd_ready=0 in SETUP/ACCESS/RESP.
//  Back-to-back: after response handshake, next command accepted in IDLE the following cycle;
//   psel never asserted two consecutive transfers without an intervening idle cycle.
//  paddr/pwrite/pwdata/pstrb retain last values when psel=0.
//  Reset mid-transfer: psel/penable drop asynchronously; transfer and pending response lost.
// TESTING
//  T1 write 0x14 data 0xA5A5_0001 strb 0xF, pready=1 -> SETUP then ACCESS, psel=0001, rsp_err=0.
//  T2 read 0x1008 (slave 1), pready low 2 cycles, prdata=0xDEAD_BEEF -> psel=0010, penable 3
//   cycles, rsp_rdata=0xDEAD_BEEF, pstrb=0.
//  T3 NSLV=3, read 0x3000 -> no psel, rsp_valid 1 cycle after accept, rsp_err=1, rsp_tout=0.
//  T4 pready stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_tout=1, psel=0.
//  T5 pslverr=1 with pready on write -> rsp_err=1; rsp_ready held low 5 cycles -> rsp stable,
//   cmd_ready=0 throughout.
//  T6 prst_n low during ACCESS -> psel/penable/rsp_valid 0 immediately, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Bundle of the requester-side command/response handshake and the APB bus.
//   master : view used by the bridge (drives cmd_ready, rsp_*, psel/penable/paddr/...)
//   slave  : view used by the surrounding system (drives cmd_*, rsp_ready, pready/prdata/pslverr)
// Command : cmd_valid/cmd_ready handshake carrying write, addr, wdata, strb.
// Response: rsp_valid/rsp_ready handshake carrying rdata, err, tout.
// APB     : psel (one-hot, NSLV wide), penable, pwrite, paddr, pwdata, pstrb, pready,
//           prdata, pslverr.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSLV   = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tout;

  // APB
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: turns one valid/ready command into an APB SETUP/ACCESS transfer to one
// of NSLV slaves, selected by paddr[SLV_LSB +: SW], and returns a held response.
// Ports:
//   pclk   : APB clock, rising edge
//   prst_n : asynchronous active-low reset
//   bus    : apb_master_bridge_if.master (command, response and APB signals)
// Out-of-range slave index gives an immediate decode-error response with no APB activity.
// An ACCESS phase waiting TIMEOUT cycles for pready is aborted with err=1, tout=1.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SLV_LSB = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                  pclk,
  input logic                  prst_n,
  apb_master_bridge_if.master  bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SW     = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned TW     = $clog2(TIMEOUT);
  localparam logic [SW:0]   NslvW     = (SW + 1)'(NSLV);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tout_q, rsp_tout_d;

  logic [SW-1:0]     cmd_idx;
  logic              cmd_idx_ok;
  logic [NSLV-1:0]   psel_c;

  assign cmd_idx    = bus.cmd_addr[SLV_LSB +: SW];
  assign cmd_idx_ok = ({1'b0, cmd_idx} < NslvW);

  // Next-state and response capture
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tout_d  = rsp_tout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          pstrb_d     = bus.cmd_write ? bus.cmd_strb : '0;
          idx_d       = cmd_idx;
          timer_d     = '0;
          rsp_rdata_d = '0;
          rsp_tout_d  = 1'b0;
          if (cmd_idx_ok) begin
            rsp_err_d = 1'b0;
            state_d   = StSetup;
          end else begin
            // Decode error: respond directly, the APB bus stays idle.
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end
        end
      end

      StSetup: begin
        state_d = StAccess;
      end

      StAccess: begin
        if (bus.pready) begin
          rsp_rdata_d = bus.pwrite ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
          rsp_tout_d  = 1'b0;
          timer_d     = '0;
          state_d     = StResp;
        end else if (timer_q == TimerLast) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tout_d  = 1'b1;
          timer_d     = '0;
          state_d     = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StResp: begin
        timer_d = '0;
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      timer_q     <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tout_q  <= rsp_tout_d;
    end
  end

  // psel/penable decode straight from the state register so that reset drops them at once.
  always_comb begin
    psel_c = '0;
    if (state_q == StSetup || state_q == StAccess) begin
      psel_c[idx_q] = 1'b1;
    end
  end

  assign bus.psel      = psel_c;
  assign bus.penable   = (state_q == StAccess);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tout  = rsp_tout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with NSLV=3 (so slave index 3 is a decode error).
// Expected responses are queued when a command is issued and compared at the response handshake.
module tb_apb_master_bridge;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NSLV    = 3;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } rsp_t;

  logic pclk;
  logic prst_n;
  int   n_total;
  int   n_bad;
  rsp_t sb_q[$];

  // Slave model configuration
  int          wait_n;
  logic        stuck;
  logic        slv_err;
  logic [31:0] slv_rdata;
  int          acc_cnt;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) bus ();

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NSLV   (NSLV),
    .SLV_LSB(12),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk  (pclk),
    .prst_n(prst_n),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave: pready rises after wait_n low ACCESS cycles unless stuck.
  always @(negedge pclk) begin
    if (bus.penable) begin
      bus.pready  = !stuck && (acc_cnt >= wait_n);
      bus.prdata  = slv_rdata;
      bus.pslverr = slv_err;
      acc_cnt     = acc_cnt + 1;
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = '0;
      acc_cnt     = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                      input logic stuck_i, input logic err_i, input logic [31:0] rdat_i,
                      input logic [2:0] exp_psel, input int hold);
    rsp_t e;
    rsp_t got_e;
    int   lat;
    int   acc;
    int   exp_acc;
    logic dec_err;
    dec_err   = (exp_psel == 3'b000);
    wait_n    = waits;
    stuck     = stuck_i;
    slv_err   = err_i;
    slv_rdata = rdat_i;
    if (dec_err) begin
      e = '{rdata: 32'h0, err: 1'b1, tout: 1'b0};
      exp_acc = 0;
    end else if (stuck_i) begin
      e = '{rdata: 32'h0, err: 1'b1, tout: 1'b1};
      exp_acc = TIMEOUT;
    end else begin
      e = '{rdata: (wr ? 32'h0 : rdat_i), err: err_i, tout: 1'b0};
      exp_acc = waits + 1;
    end
    sb_q.push_back(e);

    @(negedge pclk);
    check_eq({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;

    lat = 0;
    acc = 0;
    do begin
      @(negedge pclk);
      lat++;
      if (lat == 1) begin
        check_eq({tag, ".setup_psel"}, 64'(bus.psel), 64'(exp_psel));
        check_eq({tag, ".setup_pen"}, 64'(bus.penable), 64'd0);
        if (!dec_err) begin
          check_eq({tag, ".paddr"}, 64'(bus.paddr), 64'(addr));
          check_eq({tag, ".pwrite"}, 64'(bus.pwrite), 64'(wr));
          check_eq({tag, ".pstrb"}, 64'(bus.pstrb), 64'(wr ? strb : 4'h0));
          if (wr) check_eq({tag, ".pwdata"}, 64'(bus.pwdata), 64'(wdata));
        end
      end
      if (bus.penable) begin
        acc++;
        if (bus.psel !== exp_psel) check_eq({tag, ".acc_psel"}, 64'(bus.psel), 64'(exp_psel));
      end
    end while (!bus.rsp_valid && lat < 64);

    check_eq({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check_eq({tag, ".latency"}, 64'(lat), 64'(dec_err ? 1 : 2 + exp_acc));
    check_eq({tag, ".acc_cycles"}, 64'(acc), 64'(exp_acc));
    check_eq({tag, ".resp_psel"}, 64'(bus.psel), 64'd0);
    check_eq({tag, ".resp_pen"}, 64'(bus.penable), 64'd0);

    for (int i = 0; i < hold; i++) begin
      check_eq({tag, ".hold_valid"}, 64'(bus.rsp_valid), 64'd1);
      check_eq({tag, ".hold_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
      check_eq({tag, ".hold_err"}, 64'(bus.rsp_err), 64'(e.err));
      check_eq({tag, ".hold_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
      @(negedge pclk);
    end

    got_e = sb_q.pop_front();
    check_eq({tag, ".rsp_rdata"}, 64'(bus.rsp_rdata), 64'(got_e.rdata));
    check_eq({tag, ".rsp_err"}, 64'(bus.rsp_err), 64'(got_e.err));
    check_eq({tag, ".rsp_tout"}, 64'(bus.rsp_tout), 64'(got_e.tout));
    bus.rsp_ready = 1'b1;
    @(posedge pclk);
    #1;
    bus.rsp_ready = 1'b0;
    stuck = 1'b0;
  endtask

  initial begin
    int guard;
    n_total = 0;
    n_bad = 0;
    wait_n = 0;
    stuck = 1'b0;
    slv_err = 1'b0;
    slv_rdata = '0;
    acc_cnt = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
    prst_n = 1'b0;

    #12;
    check_eq("rst.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_eq("rst.psel", 64'(bus.psel), 64'd0);
    check_eq("rst.penable", 64'(bus.penable), 64'd0);
    check_eq("rst.pwrite", 64'(bus.pwrite), 64'd0);
    check_eq("rst.paddr", 64'(bus.paddr), 64'd0);
    check_eq("rst.pwdata", 64'(bus.pwdata), 64'd0);
    check_eq("rst.pstrb", 64'(bus.pstrb), 64'd0);
    check_eq("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_eq("rst.rsp_err", 64'(bus.rsp_err), 64'd0);
    check_eq("rst.rsp_tout", 64'(bus.rsp_tout), 64'd0);
    @(negedge pclk);
    prst_n = 1'b1;

    //     tag    wr    addr          wdata          strb  wt stk err rdata          psel    hold
    xfer("t1",  1'b1, 32'h0000_0014, 32'hA5A5_0001, 4'hF, 0, 0, 0, 32'h0,         3'b001, 0);
    xfer("t2",  1'b0, 32'h0000_1008, 32'h0,         4'hF, 2, 0, 0, 32'hDEAD_BEEF, 3'b010, 0);
    xfer("t3",  1'b0, 32'h0000_3000, 32'h0,         4'h0, 0, 0, 0, 32'h1234_5678, 3'b000, 0);
    xfer("t4",  1'b0, 32'h0000_2004, 32'h0,         4'h0, 0, 1, 0, 32'h5555_5555, 3'b100, 0);
    xfer("t5",  1'b1, 32'h0000_1010, 32'h0BAD_F00D, 4'h3, 0, 0, 1, 32'h7777_7777, 3'b010, 5);
    xfer("rd2", 1'b0, 32'h0000_2ffc, 32'h0,         4'h0, 1, 0, 0, 32'hCAFE_0042, 3'b100, 2);
    xfer("rde", 1'b0, 32'h0000_0100, 32'h0,         4'h0, 3, 0, 1, 32'h0000_00FF, 3'b001, 0);

    // T6: reset while the slave holds off pready
    stuck = 1'b1;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_2000;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge pclk);
      guard++;
    end while (!bus.penable && guard < 8);
    check_eq("t6.in_access", 64'(bus.penable), 64'd1);
    #2;
    prst_n = 1'b0;
    #1;
    check_eq("t6.psel", 64'(bus.psel), 64'd0);
    check_eq("t6.penable", 64'(bus.penable), 64'd0);
    check_eq("t6.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge pclk);
    prst_n = 1'b1;
    stuck = 1'b0;
    @(negedge pclk);
    check_eq("t6.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_eq("t6.rsp_valid_after", 64'(bus.rsp_valid), 64'd0);

    xfer("post", 1'b1, 32'h0000_0020, 32'h1111_2222, 4'hC, 1, 0, 0, 32'h0, 3'b001, 1);

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
